// File: rtl/ppu_types_pkg.sv
// Shared PPU types and scanline timing constants.
package ppu_types_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } ppu_mode_t;

  localparam logic [8:0] DOTS_PER_LINE = 9'd456;
  localparam logic [8:0] OAM_DOTS      = 9'd80;
  localparam logic [7:0] VISIBLE_LINES = 8'd144;
  localparam logic [7:0] TOTAL_LINES   = 8'd154;

  localparam logic [8:0] LAST_DOT  = DOTS_PER_LINE - 9'd1;
  localparam logic [8:0] FLUSH_DOT = OAM_DOTS - 9'd1;
  localparam logic [7:0] LAST_LINE = TOTAL_LINES - 8'd1;

endpackage

// File: rtl/ppu_stat_irq_gen.sv
// STAT interrupt source evaluation and edge detection.
// PPU_STAT_BLOCKING_EN selects DMG-style edge detection on the OR of all sources.
module ppu_stat_irq_gen
  import ppu_types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  ppu_mode_t  mode_next,
  input  logic       lyc_match_next,
  input  logic [3:0] stat_sel,
  output logic       stat_irq
);

  logic [3:0] src_d, src_q;
  logic       irq_d, irq_q;

  // Sources are evaluated on next-cycle mode/ly so the pulse lines up with them.
  always_comb begin
    src_d = '0;
    irq_d = 1'b0;
    if (!clear) begin
      src_d[0] = (mode_next == MODE_HBLANK) & stat_sel[0];
      src_d[1] = (mode_next == MODE_VBLANK) & stat_sel[1];
      src_d[2] = (mode_next == MODE_OAM)    & stat_sel[2];
      src_d[3] = lyc_match_next             & stat_sel[3];
`ifdef PPU_STAT_BLOCKING_EN
      irq_d = (|src_d) & ~(|src_q);
`else
      irq_d = |(src_d & ~src_q);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      irq_q <= 1'b0;
    end else begin
      src_q <= src_d;
      irq_q <= irq_d;
    end
  end

  assign stat_irq = irq_q;

endmodule

// File: rtl/ppu_mode_sequencer.sv
// Dot/scanline timing controller: OAM scan, transfer, HBlank, VBlank sequencing.
// Build option PPU_STAT_BLOCKING_EN is handled inside ppu_stat_irq_gen.
module ppu_mode_sequencer
  import ppu_types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       line_done,
  input  logic [3:0] stat_sel,
  input  logic [7:0] lyc,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic       oam_scan_en,
  output logic       flush,
  output logic       pixel_transfer_en,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       frame_start,
  output logic       xfer_overrun
);

  ppu_mode_t  state_q, state_d;
  logic       active_q, active_d;
  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic       flush_q, flush_d;
  logic       vblank_q, vblank_d;
  logic       frame_start_q, frame_start_d;
  logic       overrun_q, overrun_d;
  logic       wrap;

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    dot_d         = dot_q;
    ly_d          = ly_q;
    flush_d       = 1'b0;
    vblank_d      = 1'b0;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    wrap          = (dot_q == LAST_DOT);

    if (!lcd_en) begin
      state_d   = MODE_HBLANK;
      active_d  = 1'b0;
      dot_d     = '0;
      ly_d      = '0;
      overrun_d = 1'b0;
    end else if (!active_q) begin
      active_d      = 1'b1;
      state_d       = MODE_OAM;
      dot_d         = '0;
      ly_d          = '0;
      frame_start_d = 1'b1;
    end else begin
      dot_d = wrap ? '0 : dot_q + 9'd1;
      if (wrap) ly_d = (ly_q == LAST_LINE) ? '0 : ly_q + 8'd1;

      unique case (state_q)
        MODE_OAM: begin
          if (dot_q == FLUSH_DOT) state_d = MODE_XFER;
        end
        MODE_XFER, MODE_HBLANK: begin
          // An unfinished transfer at the wrap abandons the line like HBlank does.
          if (wrap) begin
            state_d  = (ly_d < VISIBLE_LINES) ? MODE_OAM : MODE_VBLANK;
            vblank_d = (ly_d == VISIBLE_LINES);
          end else if (state_q == MODE_XFER && line_done) begin
            state_d = MODE_HBLANK;
          end
        end
        MODE_VBLANK: begin
          if (wrap && ly_d == '0) begin
            state_d       = MODE_OAM;
            frame_start_d = 1'b1;
          end
        end
      endcase

      flush_d = (state_d == MODE_OAM) && (dot_d == FLUSH_DOT);
      if (state_d == MODE_XFER && dot_d == LAST_DOT) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= MODE_HBLANK;
      active_q      <= 1'b0;
      dot_q         <= '0;
      ly_q          <= '0;
      flush_q       <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      dot_q         <= dot_d;
      ly_q          <= ly_d;
      flush_q       <= flush_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
    end
  end

  ppu_stat_irq_gen u_stat_irq_gen (
    .clk            (clk),
    .reset          (reset),
    .clear          (!lcd_en),
    .mode_next      (state_d),
    .lyc_match_next (ly_d == lyc),
    .stat_sel       (stat_sel),
    .stat_irq       (stat_irq)
  );

  assign mode              = state_q;
  assign ly                = ly_q;
  assign dot               = dot_q;
  assign oam_scan_en       = (state_q == MODE_OAM);
  assign flush             = flush_q;
  assign pixel_transfer_en = (state_q == MODE_XFER) && !line_done;
  assign lyc_match         = (ly_q == lyc);
  assign vblank_irq        = vblank_q;
  assign frame_start       = frame_start_q;
  assign xfer_overrun      = overrun_q;

endmodule
